// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_pkg
//  Description : Shared RV32 fetch-side definitions: data width, canonical
//                NOP encoding and the fetch state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_VALID = 2'd1,
    ST_ERR   = 2'd2
  } fetch_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/ifu_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_wait_counter
//  Description : Counts unacknowledged request cycles. tc_o is high while the
//                count sits at TIMEOUT-1, i.e. during the last permitted
//                cycle of waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_wait_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int            W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0]  TC_VAL = W'(TIMEOUT - 1);
  localparam logic [W-1:0]  ONE    = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule : ifu_wait_counter
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage. Holds the PC, reads instruction words over a
//                req/ack handshake, registers them for decode, accepts PC
//                redirects and flags misaligned targets / memory timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              TIMEOUT   = 16,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            cnt_clr, cnt_en, cnt_tc;

  ifu_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clr),
    .enable_i (cnt_en),
    .tc_o     (cnt_tc)
  );

  // Next-state logic: redirect overrides both ack and consume
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    err_d    = err_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    if (redirect_valid && (state_q != ST_ERR)) begin
      // Any held instruction is dropped; a coincident consume is implied
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (redirect_target[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = ST_ERR;
      end else begin
        pc_d    = redirect_target;
        cnt_clr = 1'b1;
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_ack) begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            pc_d     = pc_q + 32'd4;
            valid_d  = 1'b1;
            cnt_clr  = 1'b1;
            state_d  = ST_VALID;
          end else if (cnt_tc) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = ST_REQ;
          end
        end
        ST_ERR: begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
        default: begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      endcase
    end
  end

  // State, PC and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + 32'd4;
  assign fetch_err   = err_q;

endmodule : instr_fetch_unit
`default_nettype wire
